// File: rtl/alu_sliced_pkg.sv
// Shared definitions for the slice-serial ALU: op codes, flag bit positions,
// slice modes and op-classification helpers.
package alu_sliced_pkg;

  localparam logic [3:0] SALU_ADD   = 4'd0;
  localparam logic [3:0] SALU_ADC   = 4'd1;
  localparam logic [3:0] SALU_SUB   = 4'd2;
  localparam logic [3:0] SALU_SBC   = 4'd3;
  localparam logic [3:0] SALU_AND   = 4'd4;
  localparam logic [3:0] SALU_OR    = 4'd5;
  localparam logic [3:0] SALU_XOR   = 4'd6;
  localparam logic [3:0] SALU_CP    = 4'd7;
  localparam logic [3:0] SALU_ADD16 = 4'd8;

  // Flag vector layout is {Z,N,H,C}.
  localparam int ALU_FLAG_ZERO      = 3;
  localparam int ALU_FLAG_SUB       = 2;
  localparam int ALU_FLAG_HALFCARRY = 1;
  localparam int ALU_FLAG_CARRY     = 0;

  typedef enum logic [2:0] {
    MODE_ADD,
    MODE_SUB,
    MODE_AND,
    MODE_OR,
    MODE_XOR,
    MODE_NONE
  } sliceMode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic saluIsSub(input logic [3:0] op);
    return (op == SALU_SUB) || (op == SALU_SBC) || (op == SALU_CP);
  endfunction

  function automatic logic saluIs16(input logic [3:0] op);
    return op == SALU_ADD16;
  endfunction

  function automatic sliceMode_t saluMode(input logic [3:0] op);
    case (op)
      SALU_ADD, SALU_ADC, SALU_ADD16: return MODE_ADD;
      SALU_SUB, SALU_SBC, SALU_CP:    return MODE_SUB;
      SALU_AND:                       return MODE_AND;
      SALU_OR:                        return MODE_OR;
      SALU_XOR:                       return MODE_XOR;
      default:                        return MODE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_sliced_slice.sv
// Combinational SLICE_W-bit ALU slice; exposes the carry/borrow out of every
// bit so the parent can tap the half-carry position.
module alu_slice
  import alu_sliced_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  input  sliceMode_t         mode,
  output logic [SLICE_W-1:0] result,
  output logic [SLICE_W-1:0] carries,
  output logic               cout
);

  logic c;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    result  = '0;
    carries = '0;
    c       = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      case (mode)
        MODE_ADD: begin
          result[i]  = a[i] ^ b[i] ^ c;
          c          = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
          carries[i] = c;
        end
        // c is a borrow here: a - b - borrowIn.
        MODE_SUB: begin
          result[i]  = a[i] ^ b[i] ^ c;
          c          = (~a[i] & b[i]) | (c & ~(a[i] ^ b[i]));
          carries[i] = c;
        end
        MODE_AND: result[i] = a[i] & b[i];
        MODE_OR:  result[i] = a[i] | b[i];
        MODE_XOR: result[i] = a[i] ^ b[i];
        default:  result[i] = 1'b0;
      endcase
    end
    cout = carries[SLICE_W-1];
  end

endmodule

// File: rtl/alu_sliced.sv
// Slice-serial Game Boy ALU: one SLICE_W-bit slice per clock behind
// valid/ready handshakes, producing LR35902 {Z,N,H,C} flags.
module alu_sliced
  import alu_sliced_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic [3:0]  fIn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] O,
  output logic [3:0]  fOut
);

  if (!(SLICE_W == 1 || SLICE_W == 2 || SLICE_W == 4 || SLICE_W == 8)) begin : gBadSliceW
    $error("alu_sliced: SLICE_W must be 1, 2, 4 or 8");
  end

  localparam logic [3:0] LAST8   = 4'(8 / SLICE_W - 1);
  localparam logic [3:0] LAST16  = 4'(16 / SLICE_W - 1);
  localparam logic [3:0] H8_CNT  = 4'(3 / SLICE_W);
  localparam logic [3:0] H16_CNT = 4'(11 / SLICE_W);
  localparam int         H8_IDX  = 3 % SLICE_W;
  localparam int         H16_IDX = 11 % SLICE_W;

  state_t             state, stateNext;
  logic [3:0]         opReg, fInReg, cnt;
  logic [15:0]        xSh, ySh, resSh;
  logic               carry, hReg;
  logic [SLICE_W-1:0] zAcc;

  logic               accept, is16, lastSlice, hNext, zeroNext;
  sliceMode_t         mode;
  logic [SLICE_W-1:0] sliceRes, sliceCarries, keepSlice;
  logic               sliceCout;
  logic [15:0]        resNext, resFinal;
  logic [3:0]         fFinal;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  assign mode = saluMode(opReg);
  assign is16 = saluIs16(opReg);

  alu_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a       (xSh[SLICE_W-1:0]),
    .b       (ySh[SLICE_W-1:0]),
    .cin     (carry),
    .mode    (mode),
    .result  (sliceRes),
    .carries (sliceCarries),
    .cout    (sliceCout)
  );

  assign lastSlice = (cnt == (is16 ? LAST16 : LAST8));
  assign hNext     = (cnt == (is16 ? H16_CNT : H8_CNT))
                   ? (is16 ? sliceCarries[H16_IDX] : sliceCarries[H8_IDX])
                   : hReg;
  assign zeroNext  = ~|(zAcc | sliceRes);

  // CP reports X as its result while the zero flag still follows X - Y.
  assign keepSlice = (opReg == SALU_CP) ? xSh[SLICE_W-1:0] : sliceRes;
  assign resNext   = {keepSlice, resSh[15:SLICE_W]};
  assign resFinal  = is16 ? resNext : {8'h00, resNext[15:8]};

  always_comb begin
    fFinal = fInReg;
    case (opReg)
      SALU_ADD, SALU_ADC, SALU_SUB, SALU_SBC, SALU_CP: begin
        fFinal[ALU_FLAG_ZERO]      = zeroNext;
        fFinal[ALU_FLAG_SUB]       = saluIsSub(opReg);
        fFinal[ALU_FLAG_HALFCARRY] = hNext;
        fFinal[ALU_FLAG_CARRY]     = sliceCout;
      end
      SALU_AND, SALU_OR, SALU_XOR: begin
        fFinal[ALU_FLAG_ZERO]      = zeroNext;
        fFinal[ALU_FLAG_SUB]       = 1'b0;
        fFinal[ALU_FLAG_HALFCARRY] = (opReg == SALU_AND);
        fFinal[ALU_FLAG_CARRY]     = 1'b0;
      end
      SALU_ADD16: begin
        fFinal[ALU_FLAG_ZERO]      = fInReg[ALU_FLAG_ZERO];
        fFinal[ALU_FLAG_SUB]       = 1'b0;
        fFinal[ALU_FLAG_HALFCARRY] = hNext;
        fFinal[ALU_FLAG_CARRY]     = sliceCout;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = RUN;
      RUN:     if (lastSlice) stateNext = DONE;
      DONE:    if (out_ready) stateNext = in_valid ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opReg  <= '0;
      fInReg <= '0;
      cnt    <= '0;
      xSh    <= '0;
      ySh    <= '0;
      resSh  <= '0;
      carry  <= 1'b0;
      hReg   <= 1'b0;
      zAcc   <= '0;
      O      <= '0;
      fOut   <= '0;
    end else if (accept) begin
      opReg  <= op;
      fInReg <= fIn;
      xSh    <= X;
      ySh    <= Y;
      cnt    <= '0;
      carry  <= ((op == SALU_ADC) || (op == SALU_SBC)) ? fIn[ALU_FLAG_CARRY] : 1'b0;
      hReg   <= 1'b0;
      zAcc   <= '0;
    end else if (state == RUN) begin
      cnt   <= cnt + 4'd1;
      xSh   <= xSh >> SLICE_W;
      ySh   <= ySh >> SLICE_W;
      resSh <= resNext;
      carry <= sliceCout;
      hReg  <= hNext;
      zAcc  <= zAcc | sliceRes;
      if (lastSlice) begin
        O    <= resFinal;
        fOut <= fFinal;
      end
    end
  end

endmodule

// File: tb/tb_alu_sliced.sv
// Directed bench for alu_sliced: a SLICE_W=4 instance for most vectors and a
// SLICE_W=8 instance for the latency-halving cases.
module tb_alu_sliced;
  import alu_sliced_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid4 = 1'b0, inValid8 = 1'b0;
  logic        outReady4 = 1'b1, outReady8 = 1'b1;
  logic [3:0]  op = '0;
  logic [15:0] X = '0, Y = '0;
  logic [3:0]  fIn = '0;

  logic        inReady4, inReady8, outValid4, outValid8;
  logic [15:0] O4, O8;
  logic [3:0]  fOut4, fOut8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_sliced #(.SLICE_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid4), .in_ready(inReady4),
    .op(op), .X(X), .Y(Y), .fIn(fIn), .out_valid(outValid4),
    .out_ready(outReady4), .O(O4), .fOut(fOut4)
  );

  alu_sliced #(.SLICE_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid8), .in_ready(inReady8),
    .op(op), .X(X), .Y(Y), .fIn(fIn), .out_valid(outValid8),
    .out_ready(outReady8), .O(O8), .fOut(fOut8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge after the accept edge; counts edges until out_valid.
  task automatic waitResult(input bit wide, input string tag, input int expLat,
                            input logic [15:0] expO, input logic [3:0] expF);
    int cycles = 0;
    while (!(wide ? outValid8 : outValid4) && cycles < 20) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    check({tag, "_lat"}, cycles, expLat);
    check({tag, "_O"}, wide ? O8 : O4, expO);
    check({tag, "_f"}, wide ? fOut8 : fOut4, expF);
  endtask

  task automatic runOp(input bit wide, input string tag, input logic [3:0] o,
                       input logic [15:0] x, input logic [15:0] y, input logic [3:0] f,
                       input int expLat, input logic [15:0] expO, input logic [3:0] expF);
    op = o; X = x; Y = y; fIn = f;
    if (wide) inValid8 = 1'b1;
    else      inValid4 = 1'b1;
    check({tag, "_inrdy"}, wide ? inReady8 : inReady4, 1);
    @(posedge clk);
    @(negedge clk);
    inValid4 = 1'b0;
    inValid8 = 1'b0;
    waitResult(wide, tag, expLat, expO, expF);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit sawValid;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_inrdy", inReady4, 1);
    check("rst_outvld", outValid4, 0);
    check("rst_O", O4, 16'h0000);
    check("rst_f", fOut4, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);

    runOp(0, "add",   SALU_ADD,   16'h003A, 16'h00C6, 4'b0000, 2, 16'h0000, 4'b1011);
    runOp(0, "sbc",   SALU_SBC,   16'h003B, 16'h004F, 4'b0001, 2, 16'h00EB, 4'b0111);
    runOp(0, "add16", SALU_ADD16, 16'h0FFF, 16'h0001, 4'b1000, 4, 16'h1000, 4'b1010);
    runOp(0, "cp",    SALU_CP,    16'h003E, 16'h003E, 4'b0000, 2, 16'h003E, 4'b1100);
    runOp(0, "and",   SALU_AND,   16'h00F0, 16'h000F, 4'b0000, 2, 16'h0000, 4'b1010);
    runOp(0, "xor",   SALU_XOR,   16'h00FF, 16'h00FF, 4'b0111, 2, 16'h0000, 4'b1000);
    runOp(0, "adc",   SALU_ADC,   16'hAB0F, 16'hCD00, 4'b0001, 2, 16'h0010, 4'b0010);
    runOp(0, "undef", 4'hC,       16'h0012, 16'h0034, 4'b0101, 2, 16'h0000, 4'b0101);

    // Backpressure: hold the SUB result while new requests sit on the inputs.
    outReady4 = 1'b0;
    op = SALU_SUB; X = 16'h0010; Y = 16'h0001; fIn = 4'b0000;
    inValid4 = 1'b1;
    check("bp_inrdy", inReady4, 1);
    @(posedge clk);
    @(negedge clk);
    op = SALU_OR; X = 16'h0050; Y = 16'h0005;
    waitResult(0, "bp_sub", 2, 16'h000F, 4'b0110);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold", {outValid4, inReady4, fOut4, O4}, {1'b1, 1'b0, 4'b0110, 16'h000F});
    end
    outReady4 = 1'b1;
    #1;
    check("bp_inrdy_rise", inReady4, 1);
    @(posedge clk);
    @(negedge clk);
    inValid4 = 1'b0;
    waitResult(0, "bp_or", 2, 16'h0055, 4'b0000);
    @(posedge clk);
    @(negedge clk);

    // Reset during RUN slice 1 of an ADD16.
    op = SALU_ADD16; X = 16'h1234; Y = 16'h1111; fIn = 4'b0000;
    inValid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_O", O4, 16'h0000);
    check("mr_f", fOut4, 4'h0);
    check("mr_outvld", outValid4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      sawValid |= outValid4;
    end
    check("mr_novalid", sawValid, 0);
    check("mr_inrdy", inReady4, 1);

    runOp(0, "post_add", SALU_ADD,   16'h0001, 16'h0002, 4'b0000, 2, 16'h0003, 4'b0000);
    runOp(1, "w8_sbc",   SALU_SBC,   16'h003B, 16'h004F, 4'b0001, 1, 16'h00EB, 4'b0111);
    runOp(1, "w8_add16", SALU_ADD16, 16'h0FFF, 16'h0001, 4'b1000, 2, 16'h1000, 4'b1010);
    runOp(1, "w8_c16",   SALU_ADD16, 16'hF800, 16'h0800, 4'b0000, 2, 16'h0000, 4'b0011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
